// File: rtl/bus_loader_pkg.sv
// Shared definitions for the tty-driven bus loader.
// Holds the FSM state enum, command bytes and default ACK/NAK codes.
package bus_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP,
    S_RUN
  } state_e;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_G = 8'h47;

  localparam logic [7:0] ACK_DEF = 8'h06;
  localparam logic [7:0] NAK_DEF = 8'h15;

  localparam logic [2:0] SIZE_WORD = 3'd2;

endpackage

// File: rtl/bus_loader.sv
// Serial loader: takes W/R/G commands from a tty byte stream and
// drives one word-sized bus access per frame, replying ACK/NAK/data.
// Ports:
//   clk, rst                       clock, async active-high reset
//   rx_valid/rx_ready/rx_data      byte pull from the tty receiver
//   tx_valid/tx_ready/tx_data      byte push to the tty transmitter
//   addr/size/valid/write/wdata    bus request
//   rdata/ready                    bus response
//   run                            core release, sticky until reset
module bus_loader
  import bus_loader_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255,
  parameter logic [7:0]  ACK         = ACK_DEF,
  parameter logic [7:0]  NAK         = NAK_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic [31:0] addr,
  output logic [2:0]  size,
  output logic        valid,
  output logic        write,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        ready,
  output logic        run
);

  localparam logic [31:0] TMO_LIM = 32'(BUS_TIMEOUT);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] resp_q, resp_d;
  logic        write_q, write_d;
  logic        go_q, go_d;
  logic [31:0] tmo_inc;

  assign tmo_inc = tmo_q + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      tmo_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      write_q <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      write_q <= write_d;
      go_q    <= go_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    write_d = write_q;
    go_d    = go_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_ready) begin
          cnt_d = '0;
          go_d  = 1'b0;
          unique case (rx_data)
            CMD_W: begin
              write_d = 1'b1;
              state_d = S_ADDR;
            end
            CMD_R: begin
              write_d = 1'b0;
              state_d = S_ADDR;
            end
            CMD_G: begin
              write_d = 1'b0;
              go_d    = 1'b1;
              resp_d  = {24'd0, ACK};
              last_d  = 2'd0;
              state_d = S_RESP;
            end
            default: begin
              write_d = 1'b0;
              resp_d  = {24'd0, NAK};
              last_d  = 2'd0;
              state_d = S_RESP;
            end
          endcase
        end
      end
      S_ADDR: begin
        if (rx_ready) begin
          // Shift in from the top so the first byte lands in [7:0].
          addr_d = {rx_data, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            tmo_d   = '0;
            state_d = write_q ? S_DATA : S_BUS;
          end
        end
      end
      S_DATA: begin
        if (rx_ready) begin
          wdata_d = {rx_data, wdata_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            tmo_d   = '0;
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        if (ready) begin
          cnt_d   = '0;
          state_d = S_RESP;
          if (write_q) begin
            resp_d = {24'd0, ACK};
            last_d = 2'd0;
          end else begin
            resp_d = rdata;
            last_d = 2'd3;
          end
        end else begin
          tmo_d = tmo_inc;
          // Give up once the count reaches the limit; valid drops next cycle.
          if (tmo_inc == TMO_LIM) begin
            cnt_d   = '0;
            resp_d  = {24'd0, NAK};
            last_d  = 2'd0;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (tx_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == last_q) begin
            cnt_d   = '0;
            state_d = go_q ? S_RUN : S_IDLE;
          end else begin
            resp_d = {8'd0, resp_q[31:8]};
          end
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // IDLE is the reset state; keep the rx request quiet while rst is held.
  assign rx_valid = !rst && (state_q == S_IDLE ||
                             state_q == S_ADDR ||
                             state_q == S_DATA);
  assign tx_valid = (state_q == S_RESP);
  assign valid    = (state_q == S_BUS);
  assign run      = (state_q == S_RUN);
  assign tx_data  = resp_q[7:0];
  assign addr     = addr_q;
  assign wdata    = wdata_q;
  assign write    = write_q;
  assign size     = SIZE_WORD;

endmodule

// File: tb/tb_bus_loader.sv
// Self-checking bench for bus_loader.
// Scoreboard queues hold expected bus accesses and tx bytes.
module tb_bus_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic [31:0] addr;
  logic [2:0]  size;
  logic        valid;
  logic        write;
  logic [31:0] wdata;
  logic [31:0] rdata = 32'h0;
  logic        ready = 1'b0;
  logic        run;

  typedef struct packed {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
  } bus_t;

  bus_t        exp_bus[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] mem [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int vcyc   = 0;
  int viol   = 0;
  int wcnt   = 0;
  int lat    = 0;
  bit rdy_en = 1'b1;

  bus_loader #(.BUS_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .addr(addr), .size(size), .valid(valid), .write(write),
    .wdata(wdata), .rdata(rdata), .ready(ready), .run(run)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Bus responder: random latency, checks each completed access.
  always @(negedge clk) begin
    if (valid) vcyc++;
    if (valid && tx_valid) viol++;
    if (rx_valid && tx_valid) viol++;
    if (valid && rdy_en) begin
      if (wcnt >= lat) begin
        ready = 1'b1;
        rdata = mem.exists(addr) ? mem[addr] : 32'h0;
        if (exp_bus.size() == 0) begin
          chk("bus_unexp", 1, 0);
        end else begin
          bus_t e;
          e = exp_bus.pop_front();
          chk("bus_wr", {31'd0, write}, {31'd0, e.wr});
          chk("bus_addr", addr, e.a);
          chk("bus_size", {29'd0, size}, 32'd2);
          if (e.wr) begin
            chk("bus_wdata", wdata, e.d);
            mem[addr] = wdata;
          end
        end
        wcnt = 0;
        lat  = $urandom_range(0, 3);
      end else begin
        ready = 1'b0;
        wcnt++;
      end
    end else begin
      ready = 1'b0;
      if (!valid) wcnt = 0;
    end
  end

  // Transmitter sink with random backpressure.
  always @(negedge clk) begin
    tx_ready = ($urandom_range(0, 3) != 0);
    if (tx_valid && tx_ready) begin
      if (exp_tx.size() == 0)
        chk("tx_unexp", {24'd0, tx_data}, 32'hFFFF_FFFF);
      else
        chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!rx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_valid) begin
      chk("rx_wait", 0, 1);
    end else begin
      rx_data  = b;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a,
                            input logic [31:0] d, input bit with_d);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    if (with_d)
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_tx.size() != 0 || exp_bus.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, exp_tx.size() + exp_bus.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_run"}, {31'd0, run}, 0);
    chk({tag, "_valid"}, {31'd0, valid}, 0);
    chk({tag, "_write"}, {31'd0, write}, 0);
    chk({tag, "_rxv"}, {31'd0, rx_valid}, 0);
    chk({tag, "_txv"}, {31'd0, tx_valid}, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_txd"}, {24'd0, tx_data}, 0);
    chk({tag, "_size"}, {29'd0, size}, 2);
  endtask

  initial begin
    int v0;
    int rxc;
    mem[32'h1004] = 32'h1122_3344;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rxv", {31'd0, rx_valid}, 1);

    // Write frame
    exp_bus.push_back('{1'b1, 32'h1000, 32'hDEAD_BEEF});
    exp_tx.push_back(8'h06);
    send_frame(8'h57, 32'h1000, 32'hDEAD_BEEF, 1'b1);
    chk("lat_wr", {31'd0, valid}, 1);
    drain("wr_drain");

    // Read frame
    exp_bus.push_back('{1'b0, 32'h1004, 32'h0});
    exp_tx.push_back(8'h44);
    exp_tx.push_back(8'h33);
    exp_tx.push_back(8'h22);
    exp_tx.push_back(8'h11);
    send_frame(8'h52, 32'h1004, 32'h0, 1'b0);
    chk("lat_rd", {31'd0, valid}, 1);
    drain("rd_drain");

    // Unknown command, then a normal read of the written word
    v0 = vcyc;
    exp_tx.push_back(8'h15);
    send_byte(8'hAA);
    drain("unk_drain");
    chk("unk_novalid", vcyc - v0, 0);
    exp_bus.push_back('{1'b0, 32'h1000, 32'h0});
    exp_tx.push_back(8'hEF);
    exp_tx.push_back(8'hBE);
    exp_tx.push_back(8'hAD);
    exp_tx.push_back(8'hDE);
    send_frame(8'h52, 32'h1000, 32'h0, 1'b0);
    drain("rd2_drain");

    // Timeout
    rdy_en = 1'b0;
    v0 = vcyc;
    exp_tx.push_back(8'h15);
    send_frame(8'h57, 32'h2000, 32'h0000_0001, 1'b1);
    drain("tmo_drain");
    chk("tmo_cycles", vcyc - v0, 8);
    chk("tmo_idle", {31'd0, rx_valid}, 1);
    rdy_en = 1'b1;

    // Reset mid-frame
    v0 = vcyc;
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h30);
    rst = 1'b1;
    #1;
    chk_reset_vals("mid");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_novalid", vcyc - v0, 0);
    exp_bus.push_back('{1'b1, 32'h3000, 32'hCAFE_F00D});
    exp_tx.push_back(8'h06);
    send_frame(8'h57, 32'h3000, 32'hCAFE_F00D, 1'b1);
    drain("mid_drain");

    // Go
    chk("pre_go_run", {31'd0, run}, 0);
    exp_tx.push_back(8'h06);
    send_byte(8'h47);
    drain("go_drain");
    chk("go_run", {31'd0, run}, 1);
    rxc = 0;
    v0 = vcyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_valid || tx_valid || !run) rxc++;
    end
    chk("run_quiet", rxc, 0);
    chk("run_novalid", vcyc - v0, 0);

    chk("exclusive", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
